// File: rtl/ps2_line_builder.sv
// PS/2 set-2 scan-code decoder that builds a 32-character ASCII command line with backspace and Enter commit.
// Optional shift handling (lowercase letters unless shift held) is enabled with the PS2_SHIFT_EN macro.
module ps2_line_builder (
  input  logic         clock,
  input  logic         reset,
  input  logic         ps2_key_pressed,
  input  logic [7:0]   ps2_key_data,
  output logic [255:0] ps2_line_content,
  output logic         ps2_line_ready,
  output logic [5:0]   ps2_line_length
);

  localparam int MAX_CHARS = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK,
    S_COMMIT,
    S_CLEAR
  } state_t;

  state_t      r_state;
  logic [7:0]  r_chars [0:MAX_CHARS-1];
  logic [5:0]  r_length;
  logic        r_ready;

  logic [7:0]  w_ascii;
  logic        w_mapped;
  logic        w_isLetter;
  logic [7:0]  w_char;
  logic [4:0]  w_wrIdx;
  logic [4:0]  w_bsIdx;
  logic        w_full;

`ifdef PS2_SHIFT_EN
  logic        r_shift;
  logic        w_isShiftKey;

  assign w_isShiftKey = (ps2_key_data == 8'h12) || (ps2_key_data == 8'h59);
  assign w_char       = (w_isLetter && !r_shift) ? (w_ascii | 8'h20) : w_ascii;
`else
  assign w_char       = w_ascii;
`endif

  assign w_wrIdx = r_length[4:0];
  assign w_bsIdx = r_length[4:0] - 5'd1;
  assign w_full  = (r_length == 6'd32);

  // Scan code to uppercase ASCII; letters are flagged so shift can fold them to lowercase.
  always_comb begin
    w_ascii    = 8'h00;
    w_mapped   = 1'b1;
    w_isLetter = 1'b1;
    case (ps2_key_data)
      8'h1C: w_ascii = 8'h41;
      8'h32: w_ascii = 8'h42;
      8'h21: w_ascii = 8'h43;
      8'h23: w_ascii = 8'h44;
      8'h24: w_ascii = 8'h45;
      8'h2B: w_ascii = 8'h46;
      8'h34: w_ascii = 8'h47;
      8'h33: w_ascii = 8'h48;
      8'h43: w_ascii = 8'h49;
      8'h3B: w_ascii = 8'h4A;
      8'h42: w_ascii = 8'h4B;
      8'h4B: w_ascii = 8'h4C;
      8'h3A: w_ascii = 8'h4D;
      8'h31: w_ascii = 8'h4E;
      8'h44: w_ascii = 8'h4F;
      8'h4D: w_ascii = 8'h50;
      8'h15: w_ascii = 8'h51;
      8'h2D: w_ascii = 8'h52;
      8'h1B: w_ascii = 8'h53;
      8'h2C: w_ascii = 8'h54;
      8'h3C: w_ascii = 8'h55;
      8'h2A: w_ascii = 8'h56;
      8'h1D: w_ascii = 8'h57;
      8'h22: w_ascii = 8'h58;
      8'h35: w_ascii = 8'h59;
      8'h1A: w_ascii = 8'h5A;
      8'h45: begin w_ascii = 8'h30; w_isLetter = 1'b0; end
      8'h16: begin w_ascii = 8'h31; w_isLetter = 1'b0; end
      8'h1E: begin w_ascii = 8'h32; w_isLetter = 1'b0; end
      8'h26: begin w_ascii = 8'h33; w_isLetter = 1'b0; end
      8'h25: begin w_ascii = 8'h34; w_isLetter = 1'b0; end
      8'h2E: begin w_ascii = 8'h35; w_isLetter = 1'b0; end
      8'h36: begin w_ascii = 8'h36; w_isLetter = 1'b0; end
      8'h3D: begin w_ascii = 8'h37; w_isLetter = 1'b0; end
      8'h3E: begin w_ascii = 8'h38; w_isLetter = 1'b0; end
      8'h46: begin w_ascii = 8'h39; w_isLetter = 1'b0; end
      8'h29: begin w_ascii = 8'h20; w_isLetter = 1'b0; end
      default: begin
        w_mapped   = 1'b0;
        w_isLetter = 1'b0;
      end
    endcase
  end

  // COMMIT holds the line for the ready cycle and zeroes it on the way out, so it is clear from N+2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_length <= 6'd0;
      r_ready  <= 1'b0;
`ifdef PS2_SHIFT_EN
      r_shift  <= 1'b0;
`endif
      for (int i = 0; i < MAX_CHARS; i++) r_chars[i] <= 8'h00;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ps2_key_pressed) begin
            case (ps2_key_data)
              8'hF0: r_state <= S_BREAK;
              8'hE0: r_state <= S_EXT;
              8'h5A: begin
                r_state <= S_COMMIT;
                r_ready <= 1'b1;
              end
              8'h66: begin
                if (r_length != 6'd0) begin
                  r_chars[w_bsIdx] <= 8'h00;
                  r_length         <= r_length - 6'd1;
                end
              end
              default: begin
`ifdef PS2_SHIFT_EN
                if (w_isShiftKey) r_shift <= 1'b1;
                else
`endif
                if (w_mapped && !w_full) begin
                  r_chars[w_wrIdx] <= w_char;
                  r_length         <= r_length + 6'd1;
                end
              end
            endcase
          end
        end
        S_BREAK: begin
          if (ps2_key_pressed) begin
`ifdef PS2_SHIFT_EN
            if (w_isShiftKey) r_shift <= 1'b0;
`endif
            r_state <= S_IDLE;
          end
        end
        S_EXT: begin
          if (ps2_key_pressed)
            r_state <= (ps2_key_data == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        end
        S_EXT_BREAK: begin
          if (ps2_key_pressed) r_state <= S_IDLE;
        end
        S_COMMIT: begin
          for (int i = 0; i < MAX_CHARS; i++) r_chars[i] <= 8'h00;
          r_length <= 6'd0;
          r_state  <= S_CLEAR;
        end
        S_CLEAR: begin
          for (int i = 0; i < MAX_CHARS; i++) r_chars[i] <= 8'h00;
          r_length <= 6'd0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < MAX_CHARS; g++) begin : g_pack
      assign ps2_line_content[255-8*g -: 8] = r_chars[g];
    end
  endgenerate

  assign ps2_line_ready  = r_ready;
  assign ps2_line_length = r_length;

endmodule

// File: tb/tb_ps2_line_builder.sv
// Scoreboard bench for ps2_line_builder: a queue-based line model predicts every cycle's outputs.
// Compile with PS2_SHIFT_EN defined to exercise the shift-aware variant.
module tb_ps2_line_builder;

   logic         clock;
   logic         reset;
   logic         ps2_key_pressed;
   logic [7:0]   ps2_key_data;
   logic [255:0] ps2_line_content;
   logic         ps2_line_ready;
   logic [5:0]   ps2_line_length;

   int compared;
   int mismatched;

   typedef struct {
      logic [255:0] content;
      logic [5:0]   len;
      logic         ready;
   } exp_t;

   exp_t expQ[$];

   // Reference model state: the line is a byte queue, mode mirrors the decoder position.
   localparam int M_IDLE = 0, M_BREAK = 1, M_EXT = 2, M_EXTBRK = 3, M_COMMIT = 4, M_CLEAR = 5;
   int         mMode;
   logic [7:0] mLine[$];
   logic       mShift;
   logic       mReady;

   logic [7:0] letterCodes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digitCodes[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] randPool[15]    = '{8'h1C, 8'h32, 8'h16, 8'h45, 8'h29, 8'h66, 8'h5A, 8'hF0,
                                   8'hE0, 8'h75, 8'h12, 8'h59, 8'h00, 8'hFF, 8'h14};

   ps2_line_builder dut (
      .clock            (clock),
      .reset            (reset),
      .ps2_key_pressed  (ps2_key_pressed),
      .ps2_key_data     (ps2_key_data),
      .ps2_line_content (ps2_line_content),
      .ps2_line_ready   (ps2_line_ready),
      .ps2_line_length  (ps2_line_length)
   );

   // Free-running 10-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Translate a scan code into the model's character, returning 0 when unmapped.
   function automatic logic [7:0] modelChar(input logic [7:0] code, input logic shiftOn);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < 26; i++)
         if (letterCodes[i] == code) begin
`ifdef PS2_SHIFT_EN
            c = shiftOn ? (8'h41 + 8'(i)) : (8'h61 + 8'(i));
`else
            c = 8'h41 + 8'(i);
`endif
         end
      for (int i = 0; i < 10; i++)
         if (digitCodes[i] == code) c = 8'h30 + 8'(i);
      if (code == 8'h29) c = 8'h20;
      return c;
   endfunction

   function automatic exp_t modelSnapshot();
      exp_t e;
      e.content = '0;
      for (int i = 0; i < mLine.size(); i++) e.content[255-8*i -: 8] = mLine[i];
      e.len   = 6'(mLine.size());
      e.ready = mReady;
      return e;
   endfunction

   // Advance the model by one clock edge given this cycle's inputs.
   task automatic modelStep(input logic strobe, input logic [7:0] data);
      logic [7:0] c;
      mReady = 1'b0;
      case (mMode)
         M_COMMIT: begin mLine.delete(); mMode = M_CLEAR; end
         M_CLEAR:  mMode = M_IDLE;
         M_IDLE: if (strobe) begin
            if (data == 8'hF0) mMode = M_BREAK;
            else if (data == 8'hE0) mMode = M_EXT;
            else if (data == 8'h5A) begin mMode = M_COMMIT; mReady = 1'b1; end
            else if (data == 8'h66) begin
               if (mLine.size() > 0) void'(mLine.pop_back());
            end
`ifdef PS2_SHIFT_EN
            else if (data == 8'h12 || data == 8'h59) mShift = 1'b1;
`endif
            else begin
               c = modelChar(data, mShift);
               if (c != 8'h00 && mLine.size() < 32) mLine.push_back(c);
            end
         end
         M_BREAK: if (strobe) begin
            if (data == 8'h12 || data == 8'h59) mShift = 1'b0;
            mMode = M_IDLE;
         end
         M_EXT:    if (strobe) mMode = (data == 8'hF0) ? M_EXTBRK : M_IDLE;
         M_EXTBRK: if (strobe) mMode = M_IDLE;
         default:  mMode = M_IDLE;
      endcase
   endtask

   task automatic compareNext(input string tag);
      exp_t e;
      if (expQ.size() == 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s: scoreboard empty", tag);
         return;
      end
      e = expQ.pop_front();
      checkOutput({tag, ".content"}, ps2_line_content, e.content);
      checkOutput({tag, ".length"}, {250'b0, ps2_line_length}, {250'b0, e.len});
      checkOutput({tag, ".ready"}, {255'b0, ps2_line_ready}, {255'b0, e.ready});
   endtask

   // Called at posedge+1: drive one cycle of input, then compare after the next edge.
   task automatic applyStimulus(input logic strobe, input logic [7:0] data, input string tag);
      ps2_key_pressed = strobe;
      ps2_key_data    = data;
      modelStep(strobe, data);
      expQ.push_back(modelSnapshot());
      @(posedge clock);
      #1;
      compareNext(tag);
      ps2_key_pressed = 1'b0;
   endtask

   task automatic doReset(input string tag);
      ps2_key_pressed = 1'b0;
      reset = 1'b1;
      mMode = M_IDLE;
      mLine.delete();
      mShift = 1'b0;
      mReady = 1'b0;
      expQ.push_back(modelSnapshot());
      #2;
      compareNext(tag);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic typeCodes(input logic [7:0] codes[$], input string tag);
      foreach (codes[i]) applyStimulus(1'b1, codes[i], tag);
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      reset = 1'b1;
      ps2_key_pressed = 1'b0;
      ps2_key_data = 8'h00;
      mMode = M_IDLE;
      mShift = 1'b0;
      mReady = 1'b0;
      @(posedge clock);
      #1;
      doReset("reset");

      typeCodes('{8'h33, 8'h24, 8'h4B, 8'h4B, 8'h44}, "hello");
      applyStimulus(1'b0, 8'h00, "hello.idle");
`ifdef PS2_SHIFT_EN
      checkOutput("hello.text", {216'b0, ps2_line_content[255:216]}, {216'b0, 40'h68656C6C6F});
`else
      checkOutput("hello.text", {216'b0, ps2_line_content[255:216]}, {216'b0, 40'h48454C4C4F});
`endif
      checkOutput("hello.rest", {40'b0, ps2_line_content[215:0]}, 256'h0);

      doReset("reset2");
      typeCodes('{8'h1C, 8'h32, 8'hF0, 8'h1C, 8'h66}, "bksp");
      checkOutput("bksp.len", {250'b0, ps2_line_length}, 256'd1);
`ifndef PS2_SHIFT_EN
      checkOutput("bksp.text", {240'b0, ps2_line_content[255:240]}, {240'b0, 16'h4100});
`endif

      doReset("reset3");
      for (int i = 0; i < 33; i++) applyStimulus(1'b1, 8'h1C, "fill");
      checkOutput("fill.len", {250'b0, ps2_line_length}, 256'd32);
`ifndef PS2_SHIFT_EN
      checkOutput("fill.text", ps2_line_content, {32{8'h41}});
`endif
      applyStimulus(1'b1, 8'h5A, "enter");
      checkOutput("enter.ready", {255'b0, ps2_line_ready}, 256'd1);
      applyStimulus(1'b1, 8'h1C, "commitDrop");
      checkOutput("commit.cleared", ps2_line_content, 256'h0);
      applyStimulus(1'b1, 8'h1C, "clearDrop");
      applyStimulus(1'b0, 8'h00, "postClear");

      typeCodes('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h5A, 8'h1C}, "ext");
      checkOutput("ext.len", {250'b0, ps2_line_length}, 256'd1);

      doReset("reset4");
      typeCodes('{8'h16, 8'h5A}, "midCommit");
      doReset("resetInCommit");
      checkOutput("resetInCommit.ready", {255'b0, ps2_line_ready}, 256'd0);
      applyStimulus(1'b1, 8'h16, "afterReset");
      checkOutput("afterReset.text", {248'b0, ps2_line_content[255:248]}, 256'h31);

      doReset("reset5");
      typeCodes('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C}, "shift");
`ifdef PS2_SHIFT_EN
      checkOutput("shift.text", {240'b0, ps2_line_content[255:240]}, {240'b0, 16'h4161});
`else
      checkOutput("shift.text", {240'b0, ps2_line_content[255:240]}, {240'b0, 16'h4141});
`endif

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0)
            applyStimulus(1'b1, randPool[$urandom_range(0, 14)], "random");
         else
            applyStimulus(1'b0, 8'(($urandom_range(0, 255))), "randomIdle");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ps2_line_builder.md
# ps2_line_builder

Assembles the command line typed on the PS/2 keyboard. Consumes one scan-code byte per strobe from the PS/2 receiver, decodes set-2 make/break/extended sequences, and maintains a 32-character ASCII line with backspace editing. On Enter it pulses `ps2_line_ready` for one cycle. It is the stage directly upstream of the commands printer/tracker and drives that block's `ps2_line_content` and `ps2_line_ready` inputs.

## Interface
- `MAX_CHARS`, 32: line capacity in characters; fixed by the 256-bit line bus.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ps2_key_pressed`  in  1  one-cycle strobe: `ps2_key_data` holds a new scan-code byte.
- `ps2_key_data`  in  8  raw PS/2 set-2 scan-code byte.
- `ps2_line_content`  out  256  live line; char 0 in [255:248], char i in [255-8i : 248-8i]; unused slots 8'h00.
- `ps2_line_ready`  out  1  one-cycle pulse: line committed by Enter.
- `ps2_line_length`  out  6  characters currently in line, 0..32.

## Operation
- Reset values: content 256'h0, ready 0, length 0, state IDLE, shift flag 0.
- States:
  - IDLE: F0 -> BREAK; E0 -> EXT; 5A -> COMMIT; 66 -> backspace; a mapped code -> append; anything else -> ignored.
  - BREAK: next byte is consumed, produces no character, then IDLE.
  - EXT: F0 -> EXT_BREAK; any other byte is consumed and ignored, then IDLE. Extended keys, including keypad Enter, are never decoded.
  - EXT_BREAK: next byte consumed -> IDLE.
  - COMMIT: one cycle; ready=1 and content unchanged -> CLEAR.
  - CLEAR: content zeroed, length 0 -> IDLE.
- State transitions out of IDLE/BREAK/EXT/EXT_BREAK happen only on strobe cycles.
- Map (ASCII output):
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - 29 space.
- Append: write char at index `length`, then length+1.
- Full (length==32): appended chars are dropped, and line and length are unchanged.
- Backspace: if length>0, slot length-1 becomes 8'h00 and length-1. At length 0 it is a no-op.
- Enter on an empty line still pulses ready with all-zero content.
- Typematic repeats (repeated make codes) append repeatedly.

## Timing
- All outputs are registered. A character appears on `ps2_line_content` / `ps2_line_length` the edge after its strobe.
- Enter, strobe at cycle N:
  - ready is high during cycle N+1 only, with the full line still on content.
  - Content is zero and length is 0 from cycle N+2.
- Strobes arriving while in COMMIT or CLEAR are dropped. The upstream receiver's byte rate guarantees this never loses a real key.
- Strobe with an unmapped byte: no output change.
- Reset asserted mid-sequence (e.g. in BREAK or COMMIT): everything returns immediately to reset values. A pending ready pulse is cancelled.

## Configuration
- `PS2_SHIFT_EN` defined:
  - Make 12/59 sets the shift flag; break F0 12 / F0 59 clears it.
  - Letters are uppercase (0x41-0x5A) while shift is set and lowercase (0x61-0x7A) otherwise.
  - Digits are unaffected.
- Undefined:
  - No shift flag; 12/59 are treated as unmapped.
  - Letters are always uppercase.

## Test plan
- Reset, then strobe 33 (H), 24 (E), 4B (L), 4B (L), 44 (O) -> content[255:216]=48 45 4C 4C 4F, remainder 0, length 5, ready never high.
- Type "AB", send F0 1C (A release), send 66 -> length 1, content[255:248]=41, [247:240]=00, no extra char from break.
- 33 strobes of 1C -> length saturates at 32, all 32 slots 0x41. Then 5A -> ready high exactly one cycle with content all 0x41, content zero next cycle.
- Send E0 75 (up arrow) and E0 F0 75 -> no content or length change, state back to IDLE (verified by a following 1C appending 'A').
- Assert reset while in COMMIT after typing "1" -> ready 0, content 0, length 0 on reset. A 16 after release gives [255:248]=31.
- With `PS2_SHIFT_EN`: 12, 1C, F0 12, 1C -> content[255:240]=41 61. Without it, the same stimulus gives 41 41.
